// File: rtl/ap_data_tape_pkg.sv
// Shared definitions for the AP/Data tape: digit geometry, RAM sizing, the
// controller state encoding and BCD helpers.
package ap_data_tape_pkg;

  localparam int unsigned DEKATRON_WIDTH    = 10;  // cathodes per digit
  localparam int unsigned AP_DEKATRON_NUM   = 3;
  localparam int unsigned DATA_DEKATRON_NUM = 3;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned AP_BCD_W   = AP_DEKATRON_NUM * BCD_W;
  localparam int unsigned DATA_BCD_W = DATA_DEKATRON_NUM * BCD_W;
  localparam int unsigned RAM_DEPTH  = 10 ** AP_DEKATRON_NUM;
  localparam int unsigned ADDR_W     = $clog2(RAM_DEPTH);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StStepAp,
    StStepData,
    StRead,
    StLoad,
    StWrite
  } state_e;

  // One BCD digit to a one-hot cathode vector (cathode 0 in bit 0).
  function automatic logic [DEKATRON_WIDTH-1:0] bcd_to_onehot(input logic [BCD_W-1:0] bcd);
    logic [DEKATRON_WIDTH-1:0] oh;
    oh      = '0;
    oh[bcd] = 1'b1;
    return oh;
  endfunction

  // BCD pointer to a binary RAM index, MS digit in the high bits.
  function automatic logic [ADDR_W-1:0] ap_to_index(input logic [AP_BCD_W-1:0] bcd);
    int unsigned acc;
    acc = 0;
    for (int i = int'(AP_DEKATRON_NUM) - 1; i >= 0; i--) begin
      acc = acc * 10 + 32'(bcd[i*BCD_W +: BCD_W]);
    end
    return ADDR_W'(acc);
  endfunction

endpackage

// File: rtl/bcd_ripple_counter.sv
// Multi-digit BCD counter that advances one digit per step strobe, so a
// carry ripples visibly across digits the way a dekatron chain does.
//
// Ports:
//   Clk, Rst_n  clock, asynchronous active-low reset
//   step        advance the active digit by one this cycle
//   dec         direction (1 = decrement), held stable for a whole operation
//   clr         synchronous clear of all digits
//   load        synchronous parallel load of load_val
//   load_val    BCD value for load, LS digit in low bits
//   digits      current BCD value, LS digit in low bits
//   busy        a carry is pending; the next step moves the next digit
//   last        this step finishes the operation (no carry, or carry out of MS)
module bcd_ripple_counter
  import ap_data_tape_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    step,
  input  logic                    dec,
  input  logic                    clr,
  input  logic                    load,
  input  logic [DIGITS*BCD_W-1:0] load_val,
  output logic [DIGITS*BCD_W-1:0] digits,
  output logic                    busy,
  output logic                    last
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0][BCD_W-1:0] dig_q, dig_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic                         busy_q, busy_d;
  logic [BCD_W-1:0]             cur, nxt;
  logic                         wrap;

  always_comb begin
    cur  = dig_q[idx_q];
    wrap = dec ? (cur == 4'd0) : (cur == 4'd9);
    if (dec) begin
      nxt = wrap ? 4'd9 : cur - 4'd1;
    end else begin
      nxt = wrap ? 4'd0 : cur + 4'd1;
    end
    // A wrap on the MS digit is dropped, so the chain rolls over modulo 10^DIGITS.
    last = step && (!wrap || (idx_q == IdxW'(DIGITS - 1)));

    dig_d  = dig_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    if (clr) begin
      dig_d  = '0;
      idx_d  = '0;
      busy_d = 1'b0;
    end else if (load) begin
      dig_d  = load_val;
      idx_d  = '0;
      busy_d = 1'b0;
    end else if (step) begin
      dig_d[idx_q] = nxt;
      if (last) begin
        idx_d  = '0;
        busy_d = 1'b0;
      end else begin
        idx_d  = idx_q + 1'b1;
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dig_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      dig_q  <= dig_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
    end
  end

  assign digits = dig_q;
  assign busy   = busy_q;

endmodule

// File: rtl/ap_data_tape.sv
// Brainfuck tape for the DekatronPC: a decimal data pointer (AP) and the
// current cell value (Data), both kept as BCD dekatron chains, backed by a
// 10^AP_DEKATRON_NUM-cell RAM. Answers one-cycle ApRequest/DataRequest pulses
// and pulses Ready when the operation has completed.
//
// Ports:
//   Clk, Rst_n   clock, asynchronous active-low reset
//   hsClk        step strobe, one digit step per Clk edge while high
//   ApRequest    one-cycle pulse: step AP, then load Data from the new cell
//   DataRequest  one-cycle pulse: step Data, then write it back to mem[AP]
//   Dec          direction sampled with the request (1 = decrement)
//   Ready        one-cycle completion pulse
//   Address      AP, one-hot per digit, LS digit in low bits
//   Data         current cell, one-hot per digit, LS digit in low bits
//   ApZero       AP == 0
//   DataZero     Data == 0
module ap_data_tape
  import ap_data_tape_pkg::*;
(
  input  logic                                        Clk,
  input  logic                                        Rst_n,
  input  logic                                        hsClk,
  input  logic                                        ApRequest,
  input  logic                                        DataRequest,
  input  logic                                        Dec,
  output logic                                        Ready,
  output logic [AP_DEKATRON_NUM*DEKATRON_WIDTH-1:0]   Address,
  output logic [DATA_DEKATRON_NUM*DEKATRON_WIDTH-1:0] Data,
  output logic                                        ApZero,
  output logic                                        DataZero
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(RAM_DEPTH - 1);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              pend_q, pend_d;
  logic              pend_ap_q, pend_ap_d;
  logic              pend_dec_q, pend_dec_d;
  logic              dec_q, dec_d;
  logic              ready_q, ready_d;

  logic                  req_valid, req_ap, req_dec;
  logic                  ap_step, data_step, ctr_clr, data_load;
  logic                  ap_busy, ap_last, data_busy, data_last;
  logic [AP_BCD_W-1:0]   ap_bcd;
  logic [DATA_BCD_W-1:0] data_bcd;
  logic [ADDR_W-1:0]     ap_index;

  logic                  ram_we, ram_re;
  logic [ADDR_W-1:0]     ram_waddr;
  logic [DATA_BCD_W-1:0] ram_wdata;
  logic [DATA_BCD_W-1:0] rd_data_q;
  logic [DATA_BCD_W-1:0] mem [RAM_DEPTH];

  assign ap_index = ap_to_index(ap_bcd);

  // A request latched during INIT takes precedence over a fresh one; on a
  // same-edge collision ApRequest wins.
  assign req_valid = pend_q || ApRequest || DataRequest;
  assign req_ap    = pend_q ? pend_ap_q : ApRequest;
  assign req_dec   = pend_q ? pend_dec_q : Dec;

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    pend_d      = pend_q;
    pend_ap_d   = pend_ap_q;
    pend_dec_d  = pend_dec_q;
    dec_d       = dec_q;
    unique case (state_q)
      StInit: begin
        init_addr_d = init_addr_q + 1'b1;
        if (!pend_q && (ApRequest || DataRequest)) begin
          pend_d     = 1'b1;
          pend_ap_d  = ApRequest;
          pend_dec_d = Dec;
        end
        if (init_addr_q == LastAddr) state_d = StIdle;
      end
      StIdle: begin
        // Counters are never mid-ripple here; the busy check is an interlock.
        if (req_valid && !ap_busy && !data_busy) begin
          dec_d   = req_dec;
          pend_d  = 1'b0;
          state_d = req_ap ? StStepAp : StStepData;
        end
      end
      StStepAp:   if (ap_last) state_d = StRead;
      StStepData: if (data_last) state_d = StWrite;
      StRead:     state_d = StLoad;
      StLoad:     state_d = StIdle;
      StWrite:    state_d = StIdle;
      default:    state_d = StInit;
    endcase
  end

  // Output / datapath control
  always_comb begin
    ap_step   = 1'b0;
    data_step = 1'b0;
    ctr_clr   = 1'b0;
    data_load = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = ap_index;
    ram_wdata = data_bcd;
    ready_d   = 1'b0;
    unique case (state_q)
      StInit: begin
        ctr_clr   = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = init_addr_q;
        ram_wdata = '0;
      end
      StStepAp:   ap_step = hsClk;
      StStepData: data_step = hsClk;
      StRead:     ram_re = 1'b1;
      StLoad: begin
        data_load = 1'b1;
        ready_d   = 1'b1;
      end
      StWrite: begin
        ram_we  = 1'b1;
        ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      init_addr_q <= '0;
      pend_q      <= 1'b0;
      pend_ap_q   <= 1'b0;
      pend_dec_q  <= 1'b0;
      dec_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      init_addr_q <= init_addr_d;
      pend_q      <= pend_d;
      pend_ap_q   <= pend_ap_d;
      pend_dec_q  <= pend_dec_d;
      dec_q       <= dec_d;
      ready_q     <= ready_d;
    end
  end

  // Tape RAM: one write port, one synchronous read port; not reset, INIT clears it.
  always_ff @(posedge Clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) rd_data_q <= mem[ap_index];
  end

  bcd_ripple_counter #(
    .DIGITS(AP_DEKATRON_NUM)
  ) u_ap_ctr (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .step    (ap_step),
    .dec     (dec_q),
    .clr     (ctr_clr),
    .load    (1'b0),
    .load_val('0),
    .digits  (ap_bcd),
    .busy    (ap_busy),
    .last    (ap_last)
  );

  bcd_ripple_counter #(
    .DIGITS(DATA_DEKATRON_NUM)
  ) u_data_ctr (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .step    (data_step),
    .dec     (dec_q),
    .clr     (ctr_clr),
    .load    (data_load),
    .load_val(rd_data_q),
    .digits  (data_bcd),
    .busy    (data_busy),
    .last    (data_last)
  );

  for (genvar i = 0; i < AP_DEKATRON_NUM; i++) begin : g_addr
    assign Address[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] = bcd_to_onehot(ap_bcd[i*BCD_W +: BCD_W]);
  end

  for (genvar i = 0; i < DATA_DEKATRON_NUM; i++) begin : g_data
    assign Data[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] = bcd_to_onehot(data_bcd[i*BCD_W +: BCD_W]);
  end

  assign ApZero   = (ap_bcd == '0);
  assign DataZero = (data_bcd == '0);
  assign Ready    = ready_q;

endmodule

// File: tb/tb_ap_data_tape.sv
module tb_ap_data_tape;
  import ap_data_tape_pkg::*;

  logic Clk = 1'b0;
  logic Rst_n, hsClk, ApRequest, DataRequest, Dec;
  logic Ready, ApZero, DataZero;
  logic [AP_DEKATRON_NUM*DEKATRON_WIDTH-1:0]   Address;
  logic [DATA_DEKATRON_NUM*DEKATRON_WIDTH-1:0] Data;

  int n_checks = 0;
  int n_fail   = 0;

  ap_data_tape dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .hsClk      (hsClk),
    .ApRequest  (ApRequest),
    .DataRequest(DataRequest),
    .Dec        (Dec),
    .Ready      (Ready),
    .Address    (Address),
    .Data       (Data),
    .ApZero     (ApZero),
    .DataZero   (DataZero)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit ap;
    bit dec;
    int addr;
    int data;
    int lat;
  } vec_t;

  // One-hot digit chain to its decimal value; -1 if any digit is not one-hot.
  function automatic int oh_to_int(input logic [AP_DEKATRON_NUM*DEKATRON_WIDTH-1:0] v);
    int acc;
    acc = 0;
    for (int i = int'(AP_DEKATRON_NUM) - 1; i >= 0; i--) begin
      logic [DEKATRON_WIDTH-1:0] d;
      int cnt;
      int pos;
      d   = v[i*DEKATRON_WIDTH +: DEKATRON_WIDTH];
      cnt = 0;
      pos = 0;
      for (int b = 0; b < int'(DEKATRON_WIDTH); b++) begin
        if (d[b]) begin
          cnt++;
          pos = b;
        end
      end
      if (cnt != 1) return -1;
      acc = acc * 10 + pos;
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int exp_addr, input int exp_data);
    check({name, ".addr"}, oh_to_int(Address), exp_addr);
    check({name, ".data"}, oh_to_int(Data), exp_data);
    check({name, ".apzero"}, int'(ApZero), int'(exp_addr == 0));
    check({name, ".datazero"}, int'(DataZero), int'(exp_data == 0));
  endtask

  // Pulse a request for one edge (E0), then count edges until Ready; -1 on timeout.
  task automatic run_req(input bit ap, input bit dat, input bit d, output int lat);
    ApRequest   = ap;
    DataRequest = dat;
    Dec         = d;
    tick();
    ApRequest   = 1'b0;
    DataRequest = 1'b0;
    Dec         = 1'b0;
    lat = -1;
    for (int n = 1; n <= 64; n++) begin
      tick();
      if (Ready) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_op(input string name, input bit ap, input bit dat, input bit d,
                       input int exp_lat);
    int lat;
    run_req(ap, dat, d, lat);
    check({name, ".lat"}, lat, exp_lat);
    tick();
    check({name, ".ready_drop"}, int'(Ready), 0);
  endtask

  vec_t vecs[14];
  int   lat;
  int   cnt;
  int   v;
  int   k;

  initial begin
    // Starting from AP=0, all cells 0.
    vecs[0]  = '{ap: 0, dec: 0, addr: 0,   data: 1,   lat: 2};
    vecs[1]  = '{ap: 0, dec: 0, addr: 0,   data: 2,   lat: 2};
    vecs[2]  = '{ap: 0, dec: 0, addr: 0,   data: 3,   lat: 2};
    vecs[3]  = '{ap: 0, dec: 0, addr: 0,   data: 4,   lat: 2};
    vecs[4]  = '{ap: 0, dec: 0, addr: 0,   data: 5,   lat: 2};
    vecs[5]  = '{ap: 0, dec: 0, addr: 0,   data: 6,   lat: 2};
    vecs[6]  = '{ap: 1, dec: 0, addr: 1,   data: 0,   lat: 3};
    vecs[7]  = '{ap: 1, dec: 1, addr: 0,   data: 6,   lat: 3};
    vecs[8]  = '{ap: 1, dec: 1, addr: 999, data: 0,   lat: 5};
    vecs[9]  = '{ap: 0, dec: 1, addr: 999, data: 999, lat: 4};
    vecs[10] = '{ap: 0, dec: 0, addr: 999, data: 0,   lat: 4};
    vecs[11] = '{ap: 0, dec: 1, addr: 999, data: 999, lat: 4};
    vecs[12] = '{ap: 1, dec: 0, addr: 0,   data: 6,   lat: 5};
    vecs[13] = '{ap: 1, dec: 0, addr: 1,   data: 0,   lat: 3};

    Rst_n       = 1'b0;
    hsClk       = 1'b1;
    ApRequest   = 1'b0;
    DataRequest = 1'b0;
    Dec         = 1'b0;

    #1;
    check_out("reset", 0, 0);
    check("reset.ready", int'(Ready), 0);
    tick();
    tick();
    Rst_n = 1'b1;

    // INIT sweep: 1000 cycles of Ready low with zeroed outputs.
    for (int n = 1; n <= 1000; n++) begin
      tick();
      check($sformatf("init%0d.ready", n), int'(Ready), 0);
      check_out($sformatf("init%0d", n), 0, 0);
    end

    for (int i = 0; i < 14; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].ap, !vecs[i].ap, vecs[i].dec, vecs[i].lat);
      check_out($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
    end

    // Bring cell 1 up to 099; latency grows by one per trailing 9.
    v = 0;
    for (int i = 0; i < 99; i++) begin
      k = 0;
      if (v % 10 == 9) begin
        k++;
        if ((v / 10) % 10 == 9) k++;
      end
      do_op($sformatf("inc%0d", i), 1'b0, 1'b1, 1'b0, 2 + k);
      v++;
    end
    check_out("inc99", 1, 99);

    // Visible ripple 099 -> 090 -> 000 -> 100.
    DataRequest = 1'b1;
    tick();
    DataRequest = 1'b0;
    tick();
    check("rip.s1", oh_to_int(Data), 90);
    check("rip.s1.ready", int'(Ready), 0);
    tick();
    check("rip.s2", oh_to_int(Data), 0);
    check("rip.s2.datazero", int'(DataZero), 1);
    tick();
    check("rip.s3", oh_to_int(Data), 100);
    check("rip.s3.ready", int'(Ready), 0);
    tick();
    check("rip.ready", int'(Ready), 1);
    tick();
    check("rip.ready_drop", int'(Ready), 0);

    // Fresh cell 2: 000 - 1 ripples to 999, DataZero falls after the first step.
    do_op("ap2", 1'b1, 1'b0, 1'b0, 3);
    check_out("ap2", 2, 0);
    Dec         = 1'b1;
    DataRequest = 1'b1;
    tick();
    DataRequest = 1'b0;
    Dec         = 1'b0;
    tick();
    check("drip.s1", oh_to_int(Data), 9);
    check("drip.s1.datazero", int'(DataZero), 0);
    tick();
    check("drip.s2", oh_to_int(Data), 99);
    tick();
    check("drip.s3", oh_to_int(Data), 999);
    tick();
    check("drip.ready", int'(Ready), 1);
    tick();
    check("drip.ready_drop", int'(Ready), 0);

    // Both requests on one edge: only AP moves, exactly one Ready.
    do_op("both", 1'b1, 1'b1, 1'b0, 3);
    check_out("both", 3, 0);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (Ready) cnt++;
    end
    check("both.extra_ready", cnt, 0);
    do_op("back2", 1'b1, 1'b0, 1'b1, 3);
    check_out("back2", 2, 999);
    do_op("back1", 1'b1, 1'b0, 1'b1, 3);
    check_out("back1", 1, 100);

    // hsClk low for 5 cycles stretches latency by 5; an ApRequest mid-step is ignored.
    DataRequest = 1'b1;
    tick();
    DataRequest = 1'b0;
    hsClk       = 1'b0;
    lat         = -1;
    for (int n = 1; n <= 5; n++) begin
      if (n == 2) ApRequest = 1'b1;
      tick();
      ApRequest = 1'b0;
      check($sformatf("hold%0d.ready", n), int'(Ready), 0);
      check($sformatf("hold%0d.data", n), oh_to_int(Data), 100);
    end
    hsClk = 1'b1;
    for (int n = 6; n <= 64; n++) begin
      tick();
      if (Ready) begin
        lat = n;
        break;
      end
    end
    check("hold.lat", lat, 7);
    check_out("hold", 1, 101);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (Ready) cnt++;
    end
    check("hold.extra_ready", cnt, 0);

    // Reset in the middle of STEP_DATA; a request during the rerun INIT is held.
    DataRequest = 1'b1;
    tick();
    DataRequest = 1'b0;
    hsClk       = 1'b0;
    tick();
    #2;
    Rst_n = 1'b0;
    #1;
    check_out("abort", 0, 0);
    check("abort.ready", int'(Ready), 0);
    hsClk = 1'b1;
    tick();
    tick();
    Rst_n = 1'b1;
    lat   = -1;
    for (int n = 1; n <= 1100; n++) begin
      if (n == 10) DataRequest = 1'b1;
      tick();
      DataRequest = 1'b0;
      if (Ready) begin
        lat = n;
        break;
      end
    end
    check("reinit.pend_lat", lat, 1003);
    check_out("reinit.pend", 0, 1);
    tick();
    check("reinit.ready_drop", int'(Ready), 0);
    do_op("cleared1", 1'b1, 1'b0, 1'b0, 3);
    check_out("cleared1", 1, 0);
    do_op("back0", 1'b1, 1'b0, 1'b1, 3);
    check_out("back0", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
